// File: rtl/arbitro_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_pkg
//  Shared definitions for the two-lane gate arbiter.
//  - FSM state encodings (plain localparams so older tools can read them).
//  - Default lot capacity, PIN-wait limit and the widths that hold them.
//  - carril_onehot(): turns a lane index into the one-hot Grant value.
// -----------------------------------------------------------------------------
package arbitro_pkg;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] GRANT = 2'b01;
   localparam logic [1:0] DRAIN = 2'b10;

   localparam int CAPACIDAD_DEF  = 40;
   localparam int ANCHO_OCUP_DEF = 6;
   localparam int T_ESPERA_DEF   = 16;
   localparam int ANCHO_T_DEF    = 5;

   function automatic logic [1:0] carril_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/contador_ocupacion.sv
// -----------------------------------------------------------------------------
// contador_ocupacion
//  Saturating up/down count of vehicles inside the lot.
//  Ports:
//   Clk        in   rising-edge clock
//   Reset      in   synchronous, active-high
//   inc        in   one vehicle entered (saturates at CAPACIDAD)
//   dec        in   one vehicle left (floors at 0)
//   Ocupacion  out  current count
//   Lleno      out  registered Ocupacion == CAPACIDAD
// -----------------------------------------------------------------------------
module contador_ocupacion
   import arbitro_pkg::*;
#(
   parameter int CAPACIDAD  = CAPACIDAD_DEF,
   parameter int ANCHO_OCUP = ANCHO_OCUP_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  inc,
   input  logic                  dec,
   output logic [ANCHO_OCUP-1:0] Ocupacion,
   output logic                  Lleno
);

   localparam logic [ANCHO_OCUP-1:0] CAP_W = ANCHO_OCUP'(CAPACIDAD);
   localparam logic [ANCHO_OCUP-1:0] UNO   = ANCHO_OCUP'(1);

   logic [ANCHO_OCUP-1:0] ocup_q, ocup_d;
   logic                  lleno_q, lleno_d;

   // NOTE: every variable gets a default at the top of always_comb; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      ocup_d = ocup_q;
      // An entry and an exit in the same cycle cancel out, even at the limits.
      if (inc && !dec) begin
         if (ocup_q < CAP_W) ocup_d = ocup_q + UNO;
      end else if (dec && !inc) begin
         if (ocup_q != '0) ocup_d = ocup_q - UNO;
      end
      lleno_d = (ocup_d == CAP_W);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ocup_q  <= '0;
         lleno_q <= 1'b0;
      end else begin
         ocup_q  <= ocup_d;
         lleno_q <= lleno_d;
      end
   end

   assign Ocupacion = ocup_q;
   assign Lleno     = lleno_q;

endmodule

// File: rtl/arbitro_compuerta.sv
// -----------------------------------------------------------------------------
// arbitro_compuerta
//  Shares one PIN-checking gate controller between two entrance lanes.
//  Round-robin grant, mux of the granted lane onto the controller inputs,
//  saturating occupancy count (new grants refused when full) and release of a
//  lane that stalls during PIN entry.
//  Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   Vehiculo0/1, enterPin0/1,
//   Pin0/1, Termino0/1         per-lane inputs
//   Salida                     one-cycle pulse: a vehicle left the lot
//   g_Vehiculo, g_enterPin,
//   g_Pin, g_Termino           granted lane copied to the controller
//   g_Cerrado, g_Abierto,
//   g_Alarma, g_Bloqueo        controller status
//   Grant                      one-hot lane ownership
//   AlarmaCarril               alarm/block routed to the owning lane
//   Ocupacion, Lleno           vehicles inside, lot full
//   Timeout                    one-cycle pulse when a lane is dropped for PIN stall
// -----------------------------------------------------------------------------
module arbitro_compuerta
   import arbitro_pkg::*;
#(
   parameter int CAPACIDAD  = CAPACIDAD_DEF,
   parameter int ANCHO_OCUP = ANCHO_OCUP_DEF,
   parameter int T_ESPERA   = T_ESPERA_DEF,
   parameter int ANCHO_T    = ANCHO_T_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Vehiculo0,
   input  logic                  Vehiculo1,
   input  logic                  enterPin0,
   input  logic                  enterPin1,
   input  logic [7:0]            Pin0,
   input  logic [7:0]            Pin1,
   input  logic                  Termino0,
   input  logic                  Termino1,
   input  logic                  Salida,
   output logic                  g_Vehiculo,
   output logic                  g_enterPin,
   output logic [7:0]            g_Pin,
   output logic                  g_Termino,
   input  logic                  g_Cerrado,
   input  logic                  g_Abierto,
   input  logic                  g_Alarma,
   input  logic                  g_Bloqueo,
   output logic [1:0]            Grant,
   output logic [1:0]            AlarmaCarril,
   output logic [ANCHO_OCUP-1:0] Ocupacion,
   output logic                  Lleno,
   output logic                  Timeout
);

   localparam logic [ANCHO_T-1:0] T_LIMITE = ANCHO_T'(T_ESPERA - 1);
   localparam logic [ANCHO_T-1:0] T_UNO    = ANCHO_T'(1);

   logic [1:0]         state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic               rr_q, rr_d;
   logic [ANCHO_T-1:0] timer_q, timer_d;
   logic               timeout_q, timeout_d;

   // Selected-lane view: with Grant one-hot, bit 1 is the lane index.
   logic       sel;
   logic       sel_vehiculo, sel_enter, sel_termino;
   logic [7:0] sel_pin;
   logic [1:0] req;
   logic       inc;

   assign sel          = grant_q[1];
   assign sel_vehiculo = sel ? Vehiculo1 : Vehiculo0;
   assign sel_enter    = sel ? enterPin1 : enterPin0;
   assign sel_termino  = sel ? Termino1  : Termino0;
   assign sel_pin      = sel ? Pin1      : Pin0;

   assign req = {Vehiculo1, Vehiculo0} & {2{~Lleno}};

   // Only the owning lane's Termino can count, and only while it holds GRANT.
   assign inc = (state_q == GRANT) && sel_termino;

   contador_ocupacion #(
      .CAPACIDAD  (CAPACIDAD),
      .ANCHO_OCUP (ANCHO_OCUP)
   ) u_contador (
      .Clk       (Clk),
      .Reset     (Reset),
      .inc       (inc),
      .dec       (Salida),
      .Ocupacion (Ocupacion),
      .Lleno     (Lleno)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      timer_d   = timer_q;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (req != 2'b00) begin
               grant_d = req[rr_q] ? carril_onehot(rr_q) : carril_onehot(~rr_q);
               state_d = GRANT;
            end
         end

         GRANT: begin
            // The wait timer only runs while the controller is idle-waiting.
            if (sel_enter || g_Abierto || g_Bloqueo) timer_d = '0;
            else                                     timer_d = timer_q + T_UNO;

            if (sel_termino) begin
               // A tailgater keeps the lane until the controller resolves Bloqueo.
               if (!sel_vehiculo) state_d = DRAIN;
            end else if (!sel_vehiculo && !g_Abierto) begin
               state_d = DRAIN;
            end else if (timer_q == T_LIMITE) begin
               timeout_d = 1'b1;
               state_d   = DRAIN;
            end
         end

         DRAIN: begin
            timer_d = '0;
            if (g_Cerrado) begin
               state_d = IDLE;
               grant_d = 2'b00;
               rr_d    = ~sel;
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
            timer_d = '0;
         end
      endcase
   end

   // NOTE: reset is synchronous; it is just the highest-priority branch of the
   // clocked block, not an entry in the sensitivity list.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         rr_q      <= 1'b0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   // Controller inputs follow the owning lane only in GRANT; Reset forces them
   // low immediately rather than waiting for the edge.
   always_comb begin
      g_Vehiculo = 1'b0;
      g_enterPin = 1'b0;
      g_Pin      = 8'h00;
      g_Termino  = 1'b0;
      if ((state_q == GRANT) && !Reset) begin
         g_Vehiculo = sel_vehiculo;
         g_enterPin = sel_enter;
         g_Pin      = sel_pin;
         g_Termino  = sel_termino;
      end
   end

   assign Grant        = grant_q;
   assign AlarmaCarril = grant_q & {2{g_Alarma | g_Bloqueo}};
   assign Timeout      = timeout_q;

endmodule
